// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes,
// ALU operation codes and datapath mux select codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR_ADR = 4'd11,
    S_JALR_JMP = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU decoder: maps funct3 (and funct7b5 for R-type) to an ALU
// operation and flags encodings the datapath does not implement.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control,
  output logic       legal
);

  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b1;
    unique case (funct3)
      3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_control = ALU_AND;
      3'b110:  alu_control = ALU_OR;
      3'b100:  alu_control = ALU_XOR;
      3'b010:  alu_control = ALU_SLT;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Moore-style multi-cycle control FSM for the shared-memory RV32I datapath.
// Optional retired-instruction counter: define MC_CONTROLLER_RETIRE_CNT_EN.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] res_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal,
  output logic [3:0] state_o
`ifdef MC_CONTROLLER_RETIRE_CNT_EN
  ,
  output logic [31:0] instret
`endif
);

  state_t     state;
  state_t     next_state;
  logic [2:0] dec_alu;
  logic       dec_legal;
  logic       branch_legal;

  mc_alu_decoder u_alu_decoder (
    .op5         (op[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (dec_alu),
    .legal       (dec_legal)
  );

  assign branch_legal = (funct3[2:1] == 2'b00);
  assign state_o      = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= state_t'(RESET_STATE);
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        unique case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR_ADR;
          OP_LUI:            next_state = S_LUI;
          default:           next_state = S_TRAP;
        endcase
      end
      S_MEMADR:   next_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
      S_EXECR,
      S_EXECI:    next_state = dec_legal ? S_ALUWB : S_TRAP;
      S_ALUWB:    next_state = S_FETCH;
      S_BRANCH:   next_state = branch_legal ? S_FETCH : S_TRAP;
      S_JAL:      next_state = S_ALUWB;
      S_JALR_ADR: next_state = S_JALR_JMP;
      S_JALR_JMP: next_state = S_ALUWB;
      S_LUI:      next_state = S_FETCH;
      S_TRAP:     next_state = S_TRAP;
      default:    next_state = S_TRAP;
    endcase
  end

  // Reset is applied combinationally here so requests drop in the same cycle.
  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    adr_src     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    res_src     = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    imm_src     = IMM_I;
    alu_control = ALU_ADD;
    if (rst) begin
      unique case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          res_src   = RES_ALURESULT;
          pc_write  = mem_ready;
          ir_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          if (op == OP_BRANCH)   imm_src = IMM_B;
          else if (op == OP_JAL) imm_src = IMM_J;
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          if (op == OP_STORE) imm_src = IMM_S;
        end
        S_MEMREAD: begin
          adr_src  = 1'b1;
          mem_read = 1'b1;
        end
        S_MEMWB: begin
          res_src   = RES_READDATA;
          reg_write = 1'b1;
        end
        S_MEMWRITE: begin
          adr_src   = 1'b1;
          mem_write = 1'b1;
        end
        S_EXECR: begin
          alu_src_a   = SRCA_RS1;
          alu_control = dec_alu;
        end
        S_EXECI: begin
          alu_src_a   = SRCA_RS1;
          alu_src_b   = SRCB_IMM;
          alu_control = dec_alu;
        end
        S_ALUWB: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a   = SRCA_RS1;
          alu_control = ALU_SUB;
          pc_write    = branch_legal && (zero ^ funct3[0]);
        end
        S_JAL, S_JALR_JMP: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
          pc_write  = 1'b1;
        end
        S_JALR_ADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
        S_LUI: begin
          imm_src   = IMM_U;
          res_src   = RES_IMMEXT;
          reg_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      illegal <= 1'b0;
    else if (next_state == S_TRAP) illegal <= 1'b1;
  end

`ifdef MC_CONTROLLER_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                            instret <= '0;
    else if (next_state == S_FETCH && state != S_FETCH) instret <= instret + 32'd1;
  end
`endif

endmodule
